// File: rtl/nvram_pkg.sv
// Definitions shared by the hiscore NVRAM extractor and the restore block.
package nvram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_PAD_IN,
        ST_WRITE,
        ST_DRAIN,
        ST_PAD_OUT,
        ST_DONE
    } nvram_state_t;

    localparam int unsigned NVRAM_PAUSEPAD  = 4;
    localparam int unsigned NVRAM_DUMPINDEX = 4;

endpackage

// File: rtl/nvram_fifo.sv
// Small synchronous FIFO buffering dump bytes until the CPU is paused.
module nvram_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot, so a push into a full FIFO is still taken when popping.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/nvram_restore.sv
// Writes the downloaded NVRAM dump back into CMOS RAM while the CPU is paused;
// otherwise forwards the extractor's read address to the CMOS port.
module nvram_restore
    import nvram_pkg::*;
#(
    parameter int unsigned DUMPWIDTH  = 8,
    parameter int unsigned DUMPINDEX  = NVRAM_DUMPINDEX,
    parameter int unsigned PAUSEPAD   = NVRAM_PAUSEPAD,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_index,
    input  logic [7:0]           ioctl_dout,
    output logic                 ioctl_wait,
    input  logic                 paused,
    output logic                 pause_cpu,
    input  logic [DUMPWIDTH-1:0] nvram_address,
    output logic [DUMPWIDTH-1:0] cmos_addr,
    output logic [7:0]           cmos_din,
    output logic                 cmos_we,
    output logic [DUMPWIDTH:0]   load_count,
    output logic                 load_done,
    output logic                 overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = $clog2(PAUSEPAD + 2);
    localparam logic [DUMPWIDTH:0] COUNT_MAX = {1'b1, {DUMPWIDTH{1'b0}}};

    nvram_state_t           state;
    nvram_state_t           state_nxt;
    logic                   dl;
    logic                   dl_q;
    logic                   dl_rise;
    logic                   accept;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [DUMPWIDTH+7:0]   fifo_dout;
    logic [TW-1:0]          timer;
    logic [DUMPWIDTH-1:0]   ld_addr;
    logic [7:0]             ld_data;
    logic                   own_port;

    assign dl         = ioctl_download && (ioctl_index == 8'(DUMPINDEX));
    assign dl_rise    = dl && !dl_q;
    assign accept     = dl && ioctl_wr && (ioctl_addr[24:DUMPWIDTH] == '0);
    assign ioctl_wait = (fifo_count >= CW'(FIFO_DEPTH - 1));
    assign cmos_din   = ld_data;

    nvram_fifo #(
        .WIDTH (DUMPWIDTH + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept),
        .pop     (pop),
        .din     ({ioctl_addr[DUMPWIDTH-1:0], ioctl_dout}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        cmos_we   = 1'b0;
        own_port  = 1'b0;
        unique case (state)
            ST_IDLE:    if (dl_rise) state_nxt = ST_PAUSE;
            ST_PAUSE:   if (paused) state_nxt = ST_PAD_IN;
            ST_PAD_IN: begin
                own_port = 1'b1;
                if (timer == '0) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                own_port = 1'b1;
                if (!fifo_empty) state_nxt = ST_WRITE;
                else if (!dl)    state_nxt = ST_PAD_OUT;
            end
            ST_WRITE: begin
                own_port  = 1'b1;
                pop       = 1'b1;
                cmos_we   = 1'b1;
                state_nxt = ST_DRAIN;
            end
            ST_PAD_OUT: if (timer == '0) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        cmos_addr = own_port ? ld_addr : nvram_address;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_q       <= 1'b0;
            pause_cpu  <= 1'b0;
            load_count <= '0;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            timer      <= '0;
            ld_addr    <= '0;
            ld_data    <= '0;
        end else begin
            dl_q      <= dl;
            load_done <= (state == ST_DONE);
            if (accept && fifo_full && !pop) overflow <= 1'b1;
            unique case (state)
                ST_IDLE: if (dl_rise) begin
                    pause_cpu  <= 1'b1;
                    load_count <= '0;
                end
                ST_PAUSE: if (paused) timer <= TW'(PAUSEPAD);
                ST_PAD_IN: if (timer != '0) timer <= timer - 1'b1;
                // The head entry is latched here so WRITE drives a stable registered port.
                ST_DRAIN: begin
                    if (!fifo_empty) begin
                        ld_addr <= fifo_dout[DUMPWIDTH+7:8];
                        ld_data <= fifo_dout[7:0];
                    end else if (!dl) begin
                        timer <= TW'(PAUSEPAD);
                    end
                end
                ST_WRITE: if (load_count != COUNT_MAX) load_count <= load_count + 1'b1;
                ST_PAD_OUT: begin
                    if (timer != '0) timer <= timer - 1'b1;
                    else             pause_cpu <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nvram_restore.sv
// Self-checking bench for nvram_restore: idle vector table, pass-through sweep,
// directed restores and randomized restores against an ordered-write model.
module tb_nvram_restore;

    localparam int DW  = 8;
    localparam int PP  = 4;
    localparam int IDX = 4;
    localparam int FD  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_index;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic          paused;
    logic          pause_cpu;
    logic [DW-1:0] nvram_address;
    logic [DW-1:0] cmos_addr;
    logic [7:0]    cmos_din;
    logic          cmos_we;
    logic [DW:0]   load_count;
    logic          load_done;
    logic          overflow;

    nvram_restore #(
        .DUMPWIDTH  (DW),
        .DUMPINDEX  (IDX),
        .PAUSEPAD   (PP),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_index    (ioctl_index),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .paused         (paused),
        .pause_cpu      (pause_cpu),
        .nvram_address  (nvram_address),
        .cmos_addr      (cmos_addr),
        .cmos_din       (cmos_din),
        .cmos_we        (cmos_we),
        .load_count     (load_count),
        .load_done      (load_done),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
    } byte_t;

    typedef struct {
        logic        dn;
        logic [7:0]  idx;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  nv;
        logic [7:0]  exp_cmos;
        logic        exp_pause;
    } vec_t;

    byte_t       tx[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int done_cnt, first_we_cyc, rise_cyc, fall_cyc, done_cyc;
    int dl_cyc, paused_cyc, pre_wait;
    logic prev_pause = 1'b0;

    always @(negedge clk) begin
        if (cmos_we) begin
            got_q.push_back({cmos_addr, cmos_din});
            if (first_we_cyc < 0) first_we_cyc = cyc;
        end
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (pause_cpu && !prev_pause) rise_cyc = cyc;
        if (!pause_cpu && prev_pause) fall_cyc = cyc;
        prev_pause = pause_cpu;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        done_cnt     = 0;
        first_we_cyc = -1;
        rise_cyc     = -1;
        fall_cyc     = -1;
        done_cyc     = -1;
    endtask

    // Expected writes: in-range bytes in arrival order, at most cap of them kept.
    task automatic build_exp(input int cap);
        exp_q.delete();
        foreach (tx[i])
            if (tx[i].addr < 25'h100 && exp_q.size() < cap)
                exp_q.push_back({tx[i].addr[7:0], tx[i].data});
    endtask

    task automatic send_all(input bit honour, input bit gaps);
        int  budget;
        bit  seen_wait;
        seen_wait = 0;
        pre_wait  = 0;
        foreach (tx[i]) begin
            @(posedge clk); #1;
            ioctl_wr = 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            budget = 0;
            if (ioctl_wait) seen_wait = 1;
            while (honour && ioctl_wait) begin
                budget++;
                if (budget > 2000) begin
                    errors++;
                    $display("FAIL send_timeout: ioctl_wait held %0d cycles, want release", budget);
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $fatal(1, "bridge stalled");
                end
                @(posedge clk); #1;
            end
            if (!seen_wait) pre_wait++;
            ioctl_addr = tx[i].addr;
            ioctl_dout = tx[i].data;
            ioctl_wr   = 1'b1;
        end
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("restore_completes", 64'(done_cnt != 0), 1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_restore(input int pause_delay, input bit honour, input bit gaps);
        clear_mon();
        @(posedge clk); #1;
        paused         = (pause_delay == 0);
        ioctl_index    = 8'(IDX);
        ioctl_download = 1'b1;
        dl_cyc         = cyc;
        paused_cyc     = cyc;
        fork
            begin
                if (pause_delay > 0) begin
                    repeat (pause_delay) @(posedge clk);
                    #1;
                    paused     = 1'b1;
                    paused_cyc = cyc;
                end
            end
            send_all(honour, gaps);
        join
        ioctl_download = 1'b0;
        wait_done();
    endtask

    task automatic verify(input string tag);
        int exp_lc;
        exp_lc = (exp_q.size() > 256) ? 256 : exp_q.size();
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check({tag, "_write"}, got_q[i], exp_q[i]);
        check({tag, "_load_count"}, load_count, exp_lc);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_pause_rise_lat"}, rise_cyc - dl_cyc, 1);
        check({tag, "_done_after_fall"}, done_cyc - fall_cyc, 1);
        check({tag, "_pause_released"}, pause_cpu, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   k, n;
        bit   hit;
        int   nin;

        tbl[0] = '{1'b1, 8'd5, 1'b1, 25'h010, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 8'd5, 1'b1, 25'h0FF, 8'h5A, 8'h5A, 1'b0};
        tbl[2] = '{1'b1, 8'd5, 1'b0, 25'h000, 8'hFF, 8'hFF, 1'b0};
        tbl[3] = '{1'b0, 8'd4, 1'b1, 25'h033, 8'h81, 8'h81, 1'b0};
        tbl[4] = '{1'b0, 8'd4, 1'b1, 25'h100, 8'h3C, 8'h3C, 1'b0};
        tbl[5] = '{1'b1, 8'd5, 1'b1, 25'h044, 8'h01, 8'h01, 1'b0};

        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_index    = '0;
        ioctl_dout     = '0;
        paused         = 1'b0;
        nvram_address  = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pause_cpu", pause_cpu, 0);
        check("rst_cmos_we", cmos_we, 0);
        check("rst_cmos_din", cmos_din, 0);
        check("rst_ioctl_wait", ioctl_wait, 0);
        check("rst_load_count", load_count, 0);
        check("rst_load_done", load_done, 0);
        check("rst_overflow", overflow, 0);
        reset_n = 1'b1;

        // Idle vectors: wrong index or no download must not start or feed a restore.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            ioctl_download = tbl[i].dn;
            ioctl_index    = tbl[i].idx;
            ioctl_wr       = tbl[i].wr;
            ioctl_addr     = tbl[i].addr;
            ioctl_dout     = 8'hEE;
            nvram_address  = tbl[i].nv;
            @(negedge clk);
            check("vec_cmos_addr", cmos_addr, tbl[i].exp_cmos);
            check("vec_cmos_we", cmos_we, 0);
            check("vec_pause_cpu", pause_cpu, tbl[i].exp_pause);
        end
        @(posedge clk); #1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'(IDX);
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_done", done_cnt, 0);
        check("idle_pause_cpu", pause_cpu, 0);

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            nvram_address = 8'(i);
            #1;
            check("pass_cmos_addr", cmos_addr, i);
            check("pass_cmos_we", cmos_we, 0);
        end

        tx.delete();
        for (int i = 0; i < 256; i++) tx.push_back('{25'(i), 8'(i) ^ 8'hA5});
        build_exp(1 << 30);
        do_restore(0, 1, 0);
        verify("basic");
        check("basic_overflow", overflow, 0);

        tx.delete();
        for (int i = 0; i < 12; i++) tx.push_back('{25'($urandom_range(0, 255)), 8'($urandom)});
        build_exp(1 << 30);
        do_restore(20, 1, 0);
        verify("late");
        check("late_wait_at_3", pre_wait, FD - 1);
        check("late_first_we_min", 64'((first_we_cyc - paused_cyc) >= PP + 3), 1);

        tx.delete();
        tx.push_back('{25'h010, 8'h11});
        tx.push_back('{25'h100, 8'h5A});
        tx.push_back('{25'h020, 8'h22});
        build_exp(1 << 30);
        do_restore(0, 1, 0);
        verify("oor");

        tx.delete();
        for (int i = 0; i < 6; i++) tx.push_back('{25'(8'h40 + i), 8'(8'hC0 + i)});
        build_exp(FD);
        do_restore(30, 0, 0);
        verify("ovf");
        check("ovf_flag", overflow, 1);

        tx.delete();
        for (int i = 0; i < 8; i++) tx.push_back('{25'(8'h80 + i), 8'($urandom)});
        clear_mon();
        paused = 1'b1;
        @(posedge clk); #1;
        ioctl_index    = 8'(IDX);
        ioctl_download = 1'b1;
        k   = 0;
        n   = 0;
        hit = 0;
        while (!hit && n < 200) begin
            @(posedge clk); #1;
            n++;
            ioctl_wr = 1'b0;
            if (cmos_we) hit = 1;
            else if (k < tx.size() && !ioctl_wait) begin
                ioctl_addr = tx[k].addr;
                ioctl_dout = tx[k].data;
                ioctl_wr   = 1'b1;
                k++;
            end
        end
        check("rstmid_reached_write", hit, 1);
        reset_n = 1'b0;
        #1;
        check("rstmid_pause_cpu", pause_cpu, 0);
        check("rstmid_cmos_we", cmos_we, 0);
        check("rstmid_ioctl_wait", ioctl_wait, 0);
        check("rstmid_overflow", overflow, 0);
        check("rstmid_load_count", load_count, 0);
        check("rstmid_load_done", load_done, 0);
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_mon();
        repeat (10) @(posedge clk);
        #1;
        check("rstmid_no_done", done_cnt, 0);
        check("rstmid_no_we", got_q.size(), 0);

        tx.delete();
        for (int i = 0; i < 5; i++) tx.push_back('{25'(8'hE0 + i), 8'($urandom)});
        build_exp(1 << 30);
        do_restore(0, 1, 0);
        verify("restart");

        // Long randomized dump with duplicates and stray out-of-range bytes; saturates load_count.
        tx.delete();
        nin = 0;
        while (nin < 270) begin
            if ($urandom_range(0, 7) == 0)
                tx.push_back('{25'h100 + 25'($urandom_range(0, 4095)), 8'($urandom)});
            tx.push_back('{25'($urandom_range(0, 255)), 8'($urandom)});
            nin++;
        end
        build_exp(1 << 30);
        do_restore($urandom_range(0, 10), 1, 1);
        verify("rand_big");

        tx.delete();
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 4) == 0) tx.push_back('{25'h1000 + 25'($urandom_range(0, 255)), 8'($urandom)});
            else                           tx.push_back('{25'($urandom_range(0, 255)), 8'($urandom)});
        end
        build_exp(1 << 30);
        do_restore($urandom_range(1, 25), 1, 1);
        verify("rand_small");
        check("final_overflow", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
